// File: rtl/operand_sel_stage.sv
// rtl/operand_sel_stage.sv - N-way operand select with valid/ready skid-buffered output register
// Optional sticky out-of-range select flag: define OPERAND_SEL_ERR_EN.
module operand_sel_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*WIDTH-1:0]   d_flat,
    input  logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          y,
    output logic                      sel_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] sel_word;
    logic             accept;
    logic             deliver;

    // Only indices below NUM_IN can match, so out-of-range selects fall through to zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                sel_word = d_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    // in_ready depends on state alone, keeping out_ready off the upstream timing path.
    assign in_ready  = (state != SKID);
    assign out_valid = (state != EMPTY);
    assign y         = main_q;
    assign accept    = in_valid && in_ready && !flush;
    assign deliver   = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= sel_word;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (accept && deliver) begin
                        main_q <= sel_word;
                    end else if (accept) begin
                        skid_q <= sel_word;
                        state  <= SKID;
                    end else if (deliver) begin
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    if (deliver) begin
                        main_q <= skid_q;
                        state  <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef OPERAND_SEL_ERR_EN
    logic sel_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (accept && (int'(sel) >= NUM_IN)) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_sel_stage.sv
// tb/tb_operand_sel_stage.sv - directed self-checking bench for operand_sel_stage
module tb_operand_sel_stage;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 5;

`ifdef OPERAND_SEL_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    flush = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] d_flat;
    logic [2:0]              sel = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [WIDTH-1:0]        y;
    logic                    sel_err;

    int errors = 0;
    int checks = 0;

    operand_sel_stage #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .d_flat(d_flat), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    initial d_flat = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b exp=1", in_ready); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL rst_y got=%h exp=00000000", y); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", sel_err); end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        sel = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%0b exp=1", out_valid); end
        checks++; if (y !== 32'h33333333) begin errors++; $display("FAIL lat_y got=%h exp=33333333", y); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222;
        exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 3'(i); in_valid = 1'b1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || y !== exp_w[i]) begin
                errors++; $display("FAIL b2b_y[%0d] got=%h/%0b exp=%h/1", i, y, out_valid, exp_w[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        sel = 3'd0; in_valid = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || y !== 32'h11111111) begin errors++; $display("FAIL bp_first got=%0b/%h exp=1/11111111", in_ready, y); end
        sel = 3'd1;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_ready got=%0b exp=0", in_ready); end
        sel = 3'd2;
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 32'h11111111) begin
            errors++; $display("FAIL bp_hold got=%0b/%0b/%h exp=0/1/11111111", in_ready, out_valid, y);
        end
        out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || y !== 32'h22222222) begin errors++; $display("FAIL bp_rel1 got=%0b/%h exp=1/22222222", in_ready, y); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || y !== 32'h33333333) begin errors++; $display("FAIL bp_rel2 got=%0b/%h exp=1/33333333", out_valid, y); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        sel = 3'd3; in_valid = 1'b1;
        tick();
        sel = 3'd0;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_pre got=%0b exp=0", in_ready); end
        flush = 1'b1; sel = 3'd1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fl_skid got=%0b/%0b exp=0/1", out_valid, in_ready); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_stale got=%0b exp=0", out_valid); end
        // FULL with accept, deliver and flush together ends EMPTY
        sel = 3'd2; in_valid = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fl_all got=%0b/%0b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_sel_range();
        out_ready = 1'b1;
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL sr_pre got=%0b exp=0", sel_err); end
        sel = 3'd4; in_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || y !== 32'h55555555) begin errors++; $display("FAIL sr_last got=%0b/%h exp=1/55555555", out_valid, y); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL sr_last_err got=%0b exp=0", sel_err); end
        sel = 3'd6;
        tick();
        checks++; if (out_valid !== 1'b1 || y !== 32'h0) begin errors++; $display("FAIL sr_oor got=%0b/%h exp=1/00000000", out_valid, y); end
        checks++; if (sel_err !== ERR_EXP) begin errors++; $display("FAIL sr_err got=%0b exp=%0b", sel_err, ERR_EXP); end
        sel = 3'd1;
        tick();
        checks++; if (y !== 32'h22222222) begin errors++; $display("FAIL sr_after got=%h exp=22222222", y); end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (sel_err !== ERR_EXP) begin errors++; $display("FAIL sr_sticky got=%0b exp=%0b", sel_err, ERR_EXP); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        sel = 3'd0; in_valid = 1'b1;
        tick();
        sel = 3'd1;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_pre got=%0b exp=0", in_ready); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 32'h0 || sel_err !== 1'b0) begin
            errors++; $display("FAIL ar_now got=%0b/%0b/%h/%0b exp=0/1/00000000/0", out_valid, in_ready, y, sel_err);
        end
        #2 reset = 1'b0;
        sel = 3'd3; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || y !== 32'h44444444) begin errors++; $display("FAIL ar_first got=%0b/%h exp=1/44444444", out_valid, y); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_sel_range();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
